core_rrv_fab_out_arb: RTL and testbench

Outbound fabric arbiter for the core_rrv tile. It shares the single `OutFabricQ505H` port between two requesters: core-originated remote RD/WR requests, and local RD_RSP responses to remote readers. Each requester has its own small buffer. Transactions are granted only when the XY-routed destination port's `fab_ready` bit is set. Core reads are throttled by an outstanding-read credit counter.

---
 rtl/core_rrv_pkg.sv | 42 ++++
 rtl/core_rrv_fab_out_arb_if.sv | 24 ++
 rtl/core_rrv_fab_arb_fifo.sv | 51 +++++
 rtl/core_rrv_fab_out_arb.sv | 123 ++++++++++++
 tb/tb_core_rrv_fab_out_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_rrv_pkg.sv
// Shared core_rrv types: tile transaction, opcodes, fabric port enum and the XY routing helper.
package core_rrv_pkg;

    typedef enum logic [1:0] {
        RD     = 2'd0,
        WR     = 2'd1,
        RD_RSP = 2'd2
    } t_opcode;

    typedef struct packed {
        t_opcode     opcode;
        logic [31:0] address;
        logic [31:0] data;
    } t_tile_trans;

    typedef enum logic [2:0] {
        NORTH = 3'd0,
        EAST  = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        LOCAL = 3'd4
    } t_cardinal;

    typedef logic [4:0] t_fab_ready;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_RSP  = 1'b1
    } t_req;

    // X is resolved before Y; tile ID is {X[3:0], Y[3:0]}.
    function automatic t_cardinal xy_port(input logic [7:0] local_id, input logic [7:0] dst_id);
        t_cardinal port;
        if (dst_id[7:4] > local_id[7:4])      port = EAST;
        else if (dst_id[7:4] < local_id[7:4]) port = WEST;
        else if (dst_id[3:0] > local_id[3:0]) port = SOUTH;
        else if (dst_id[3:0] < local_id[3:0]) port = NORTH;
        else                                  port = LOCAL;
        return port;
    endfunction

endpackage

// File: rtl/core_rrv_fab_out_arb_if.sv
// Handshake bundle of the outbound fabric arbiter: two request streams in, one fabric stream out.
interface core_rrv_fab_out_arb_if;
    import core_rrv_pkg::*;

    logic        CoreReqValid;
    t_tile_trans CoreReq;
    logic        CoreReqReady;
    logic        RspReqValid;
    t_tile_trans RspReq;
    logic        RspReqReady;
    logic        OutFabricValidQ505H;
    t_tile_trans OutFabricQ505H;

    modport master (
        output CoreReqValid, CoreReq, RspReqValid, RspReq,
        input  CoreReqReady, RspReqReady, OutFabricValidQ505H, OutFabricQ505H
    );

    modport slave (
        input  CoreReqValid, CoreReq, RspReqValid, RspReq,
        output CoreReqReady, RspReqReady, OutFabricValidQ505H, OutFabricQ505H
    );

endinterface

// File: rtl/core_rrv_fab_arb_fifo.sv
// Small per-requester FIFO with a registered occupancy count and a combinational head.
module core_rrv_fab_arb_fifo
    import core_rrv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  t_tile_trans data_i,
    input  logic        pop_i,
    output t_tile_trans head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    t_tile_trans   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i)      count_d = count_q + (AW+1)'(1);
        else if (!push_i && pop_i) count_d = count_q - (AW+1)'(1);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/core_rrv_fab_out_arb.sv
// Outbound fabric arbiter: core requests vs. local read responses onto one registered fabric port.
// CORE_RRV_FAB_ARB_RR_EN selects round-robin; otherwise responses have fixed priority over core.
module core_rrv_fab_out_arb
    import core_rrv_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int MAX_RD_OUT = 4
) (
    input  logic                         Clock,
    input  logic                         Rst,
    input  logic [7:0]                   local_tile_id,
    core_rrv_fab_out_arb_if.slave        bus,
    input  logic                         InRdRspValid,
    input  t_fab_ready                   fab_ready,
    output logic [3:0]                   RdOutstanding,
    output logic                         ArbIdle
);

    localparam logic [3:0] RD_LIMIT = 4'(MAX_RD_OUT);

    t_tile_trans core_head, rsp_head;
    logic        core_full, core_empty, rsp_full, rsp_empty;
    logic        core_push, rsp_push;
    logic        core_elig, rsp_elig, gnt_core, gnt_rsp, rd_inc;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic        out_vld_q, out_vld_d;
    t_tile_trans out_trans_q, out_trans_d;

    function automatic logic head_eligible(input t_tile_trans head, input logic empty,
                                           input logic [7:0] local_id, input t_fab_ready rdy,
                                           input logic credit_ok);
        return !empty && rdy[xy_port(local_id, head.address[31:24])]
               && (head.opcode != RD || credit_ok);
    endfunction

    assign core_push        = bus.CoreReqValid && !core_full;
    assign rsp_push         = bus.RspReqValid && !rsp_full;
    assign bus.CoreReqReady = !core_full;
    assign bus.RspReqReady  = !rsp_full;

    core_rrv_fab_arb_fifo #(.DEPTH(DEPTH)) u_core_fifo (
        .clk_i   (Clock),
        .rst_i   (Rst),
        .push_i  (core_push),
        .data_i  (bus.CoreReq),
        .pop_i   (gnt_core),
        .head_o  (core_head),
        .full_o  (core_full),
        .empty_o (core_empty)
    );

    core_rrv_fab_arb_fifo #(.DEPTH(DEPTH)) u_rsp_fifo (
        .clk_i   (Clock),
        .rst_i   (Rst),
        .push_i  (rsp_push),
        .data_i  (bus.RspReq),
        .pop_i   (gnt_rsp),
        .head_o  (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty)
    );

    assign core_elig = head_eligible(core_head, core_empty, local_tile_id, fab_ready,
                                     rd_cnt_q < RD_LIMIT);
    assign rsp_elig  = head_eligible(rsp_head, rsp_empty, local_tile_id, fab_ready,
                                     rd_cnt_q < RD_LIMIT);

`ifdef CORE_RRV_FAB_ARB_RR_EN
    t_req last_grant_q;

    // On a tie the requester not served last wins; reset favours core first.
    always_comb begin
        gnt_core = core_elig;
        gnt_rsp  = rsp_elig;
        if (core_elig && rsp_elig) begin
            gnt_core = (last_grant_q == REQ_RSP);
            gnt_rsp  = (last_grant_q == REQ_CORE);
        end
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst)                      last_grant_q <= REQ_RSP;
        else if (gnt_core || gnt_rsp) last_grant_q <= gnt_rsp ? REQ_RSP : REQ_CORE;
    end
`else
    assign gnt_rsp  = rsp_elig;
    assign gnt_core = core_elig && !rsp_elig;
`endif

    assign rd_inc = (gnt_core && core_head.opcode == RD) || (gnt_rsp && rsp_head.opcode == RD);

    // A return at zero is dropped so credits lost to a reset cannot underflow.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (rd_inc && !InRdRspValid)                        rd_cnt_d = rd_cnt_q + 4'd1;
        else if (!rd_inc && InRdRspValid && rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - 4'd1;
    end

    always_comb begin
        out_vld_d   = gnt_core || gnt_rsp;
        out_trans_d = out_trans_q;
        if (gnt_rsp)       out_trans_d = rsp_head;
        else if (gnt_core) out_trans_d = core_head;
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            out_vld_q   <= 1'b0;
            out_trans_q <= '0;
            rd_cnt_q    <= '0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_trans_q <= out_trans_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    assign bus.OutFabricValidQ505H = out_vld_q;
    assign bus.OutFabricQ505H      = out_trans_q;
    assign RdOutstanding           = rd_cnt_q;
    assign ArbIdle                 = core_empty && rsp_empty && (rd_cnt_q == '0);

endmodule

// File: tb/tb_core_rrv_fab_out_arb.sv
// Bench for core_rrv_fab_out_arb: directed scenarios plus random traffic against a queue-based model.
module tb_core_rrv_fab_out_arb;
    import core_rrv_pkg::*;

    localparam int DEPTH = 2;
    localparam int MAXRD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  loc = 8'h22;
    t_fab_ready  fab_rdy = 5'h1f;
    logic        in_rsp = 1'b0;
    logic        c_vld = 1'b0, r_vld = 1'b0;
    t_tile_trans c_req = '0, r_req = '0;
    logic [3:0]  rd_out;
    logic        idle;

    int checks = 0;
    int failures = 0;

    core_rrv_fab_out_arb_if bus_if ();
    assign bus_if.CoreReqValid = c_vld;
    assign bus_if.CoreReq      = c_req;
    assign bus_if.RspReqValid  = r_vld;
    assign bus_if.RspReq       = r_req;

    core_rrv_fab_out_arb #(.DEPTH(DEPTH), .MAX_RD_OUT(MAXRD)) dut (
        .Clock         (clk),
        .Rst           (rst),
        .local_tile_id (loc),
        .bus           (bus_if),
        .InRdRspValid  (in_rsp),
        .fab_ready     (fab_rdy),
        .RdOutstanding (rd_out),
        .ArbIdle       (idle)
    );

    always #5 clk = ~clk;

    // Reference model: queues hold FIFO contents, counters hold credits and output register.
    t_tile_trans m_core[$], m_rsp[$];
    int          m_rd;
    bit          m_last_was_rsp;
    bit          m_vld;
    t_tile_trans m_out;
    bit          acc_c, acc_r;

    function automatic int m_port(input logic [7:0] dst);
        int lx = int'(loc[7:4]);
        int ly = int'(loc[3:0]);
        int dx = int'(dst[7:4]);
        int dy = int'(dst[3:0]);
        if (dx > lx) return 1;
        if (dx < lx) return 3;
        if (dy > ly) return 2;
        if (dy < ly) return 0;
        return 4;
    endfunction

    function automatic bit m_can_send(input t_tile_trans t);
        if (fab_rdy[m_port(t.address[31:24])] != 1'b1) return 1'b0;
        if (t.opcode == RD && m_rd >= MAXRD) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_reset();
        m_core.delete();
        m_rsp.delete();
        m_rd = 0;
        m_vld = 0;
        m_out = '0;
        m_last_was_rsp = 1;
    endtask

    task automatic m_next();
        bit ce, re, take_core, take_rsp, rd_sent;
        bit room_c, room_r;
        room_c = m_core.size() < DEPTH;
        room_r = m_rsp.size() < DEPTH;
        ce = (m_core.size() > 0) && m_can_send(m_core[0]);
        re = (m_rsp.size() > 0) && m_can_send(m_rsp[0]);
`ifdef CORE_RRV_FAB_ARB_RR_EN
        if (ce && re) begin
            take_core = m_last_was_rsp;
            take_rsp  = !m_last_was_rsp;
        end else begin
            take_core = ce;
            take_rsp  = re;
        end
        if (take_core) m_last_was_rsp = 0;
        if (take_rsp)  m_last_was_rsp = 1;
`else
        take_rsp  = re;
        take_core = ce && !re;
`endif
        rd_sent = 0;
        m_vld = take_core || take_rsp;
        if (take_rsp) begin
            m_out = m_rsp.pop_front();
            rd_sent = (m_out.opcode == RD);
        end else if (take_core) begin
            m_out = m_core.pop_front();
            rd_sent = (m_out.opcode == RD);
        end
        if (rd_sent && !in_rsp) m_rd = m_rd + 1;
        else if (!rd_sent && in_rsp && m_rd > 0) m_rd = m_rd - 1;
        acc_c = c_vld && room_c;
        acc_r = r_vld && room_r;
        if (acc_c) m_core.push_back(c_req);
        if (acc_r) m_rsp.push_back(r_req);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":vld"},   128'(bus_if.OutFabricValidQ505H), 128'(m_vld));
        chk({tag, ":data"},  128'(bus_if.OutFabricQ505H),      128'(m_out));
        chk({tag, ":rdout"}, 128'(rd_out),                     128'(m_rd));
        chk({tag, ":crdy"},  128'(bus_if.CoreReqReady),        128'(m_core.size() < DEPTH));
        chk({tag, ":rrdy"},  128'(bus_if.RspReqReady),         128'(m_rsp.size() < DEPTH));
        chk({tag, ":idle"},  128'(idle),
            128'(m_core.size() == 0 && m_rsp.size() == 0 && m_rd == 0));
    endtask

    task automatic step(input string tag);
        m_next();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        c_vld = 0;
        r_vld = 0;
        in_rsp = 0;
        rst = 1;
        m_reset();
        #1;
        check_all("rst_async");
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        check_all("rst_rel");
    endtask

    function automatic logic [7:0] pick_tile();
        logic [7:0] tiles [9];
        tiles = '{8'h22, 8'h33, 8'h11, 8'h21, 8'h23, 8'h12, 8'h32, 8'h02, 8'h20};
        return tiles[$urandom_range(8)];
    endfunction

    initial begin
        int n, issued;
        logic [31:0] seq[$];
        logic [31:0] exp_d;

        #2;
        do_reset();
        chk("reset_vld",  128'(bus_if.OutFabricValidQ505H), 128'(0));
        chk("reset_data", 128'(bus_if.OutFabricQ505H),      128'(0));
        chk("reset_idle", 128'(idle),                       128'(1));

        // Single WR to EAST with only the EAST port ready.
        @(negedge clk);
        loc = 8'h22;
        fab_rdy = 5'b00010;
        c_vld = 1;
        c_req = '{opcode: WR, address: 32'h3300_0100, data: 32'hDEAD_BEEF};
        step("wr_acc");
        chk("wr_lat1_vld", 128'(bus_if.OutFabricValidQ505H), 128'(0));
        c_vld = 0;
        step("wr_out");
        chk("wr_lat2_vld", 128'(bus_if.OutFabricValidQ505H), 128'(1));
        chk("wr_payload", 128'(bus_if.OutFabricQ505H),
            128'({WR, 32'h3300_0100, 32'hDEAD_BEEF}));
        step("wr_after");

        // Contention: four core WRs and four RSPs offered back-to-back.
        do_reset();
        fab_rdy = 5'h1f;
        n = 0;
        issued = 0;
        seq.delete();
        for (int k = 0; k < 16; k++) begin
            c_vld = (n < 4);
            c_req = '{opcode: WR, address: 32'h3300_0000 | 32'(n), data: 32'hC000_0000 | 32'(n)};
            r_vld = (issued < 4);
            r_req = '{opcode: RD_RSP, address: 32'h1100_0000 | 32'(issued),
                      data: 32'hA000_0000 | 32'(issued)};
            step("cont");
            if (acc_c) n++;
            if (acc_r) issued++;
            if (bus_if.OutFabricValidQ505H) seq.push_back(bus_if.OutFabricQ505H.data);
        end
        c_vld = 0;
        r_vld = 0;
        chk("cont_count", 128'(seq.size()), 128'(8));
        for (int i = 0; i < 8 && i < seq.size(); i++) begin
`ifdef CORE_RRV_FAB_ARB_RR_EN
            exp_d = ((i % 2) == 0) ? (32'hC000_0000 | 32'(i / 2)) : (32'hA000_0000 | 32'(i / 2));
`else
            exp_d = (i < 4) ? (32'hA000_0000 | 32'(i)) : (32'hC000_0000 | 32'(i - 4));
`endif
            chk("cont_order", 128'(seq[i]), 128'(exp_d));
        end

        // Credit limit: six core RDs, no returns.
        do_reset();
        n = 0;
        issued = 0;
        for (int k = 0; k < 16; k++) begin
            c_vld = (n < 6);
            c_req = '{opcode: RD, address: {8'h33, 24'(n)}, data: 32'(n)};
            step("crd");
            if (acc_c) n++;
            if (bus_if.OutFabricValidQ505H) issued++;
        end
        c_vld = 0;
        chk("crd_issued", 128'(issued), 128'(4));
        chk("crd_rdout",  128'(rd_out), 128'(4));
        chk("crd_full",   128'(bus_if.CoreReqReady), 128'(0));
        in_rsp = 1;
        step("crd_ret");
        in_rsp = 0;
        chk("crd_ret_cnt", 128'(rd_out), 128'(3));
        chk("crd_ret_vld", 128'(bus_if.OutFabricValidQ505H), 128'(0));
        step("crd_5th");
        chk("crd_5th_vld",  128'(bus_if.OutFabricValidQ505H), 128'(1));
        chk("crd_5th_data", 128'(bus_if.OutFabricQ505H.data), 128'(4));
        chk("crd_5th_cnt",  128'(rd_out), 128'(4));

        // Grant and return in the same cycle; return at zero.
        do_reset();
        c_vld = 1;
        c_req = '{opcode: RD, address: 32'h3300_0000, data: 32'h0};
        step("sim_a");
        c_req = '{opcode: RD, address: 32'h3300_0001, data: 32'h1};
        step("sim_b");
        c_vld = 0;
        step("sim_c");
        step("sim_d");
        chk("sim_cnt2", 128'(rd_out), 128'(2));
        c_vld = 1;
        c_req = '{opcode: RD, address: 32'h3300_0002, data: 32'h2};
        step("sim_e");
        c_vld = 0;
        in_rsp = 1;
        step("sim_both");
        in_rsp = 0;
        chk("sim_both_vld", 128'(bus_if.OutFabricValidQ505H), 128'(1));
        chk("sim_both_cnt", 128'(rd_out), 128'(2));
        in_rsp = 1;
        step("sim_dec1");
        step("sim_dec2");
        step("sim_sat");
        in_rsp = 0;
        chk("sim_sat_cnt", 128'(rd_out), 128'(0));

        // Backpressure: RSP to NORTH blocked, core WR to EAST still flows.
        do_reset();
        loc = 8'h22;
        fab_rdy = 5'b11110;
        r_vld = 1;
        r_req = '{opcode: RD_RSP, address: 32'h2100_0000, data: 32'hA1};
        c_vld = 1;
        c_req = '{opcode: WR, address: 32'h3300_0000, data: 32'hC1};
        step("bp_push1");
        c_vld = 0;
        r_req = '{opcode: RD_RSP, address: 32'h3300_0004, data: 32'hA2};
        step("bp_push2");
        r_vld = 0;
        seq.delete();
        if (bus_if.OutFabricValidQ505H) seq.push_back(bus_if.OutFabricQ505H.data);
        for (int k = 0; k < 4; k++) begin
            step("bp_hold");
            if (bus_if.OutFabricValidQ505H) seq.push_back(bus_if.OutFabricQ505H.data);
        end
        chk("bp_blocked_cnt", 128'(seq.size()), 128'(1));
        if (seq.size() > 0) chk("bp_core_pass", 128'(seq[0]), 128'(32'hC1));
        fab_rdy = 5'b11111;
        step("bp_rel1");
        chk("bp_rel1_data", 128'(bus_if.OutFabricQ505H.data), 128'(32'hA1));
        step("bp_rel2");
        chk("bp_rel2_data", 128'(bus_if.OutFabricQ505H.data), 128'(32'hA2));

        // Reset mid-burst with queued entries and credits in use.
        do_reset();
        fab_rdy = 5'h1f;
        c_vld = 1;
        for (int k = 0; k < 3; k++) begin
            c_req = '{opcode: RD, address: {8'h33, 24'(k)}, data: 32'(k)};
            step("mid_rd");
        end
        c_vld = 0;
        step("mid_a");
        step("mid_b");
        chk("mid_cnt3", 128'(rd_out), 128'(3));
        fab_rdy = 5'h00;
        c_vld = 1;
        c_req = '{opcode: WR, address: 32'h3300_0000, data: 32'h55};
        r_vld = 1;
        r_req = '{opcode: RD_RSP, address: 32'h1100_0000, data: 32'h66};
        step("mid_q");
        c_vld = 0;
        r_vld = 0;
        step("mid_q2");
        chk("mid_busy", 128'(idle), 128'(0));
        do_reset();
        chk("mid_rst_vld",  128'(bus_if.OutFabricValidQ505H), 128'(0));
        chk("mid_rst_cnt",  128'(rd_out), 128'(0));
        chk("mid_rst_crdy", 128'(bus_if.CoreReqReady), 128'(1));
        chk("mid_rst_rrdy", 128'(bus_if.RspReqReady), 128'(1));
        chk("mid_rst_idle", 128'(idle), 128'(1));
        in_rsp = 1;
        step("mid_late_ret");
        in_rsp = 0;
        chk("mid_late_cnt", 128'(rd_out), 128'(0));

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset();
                continue;
            end
            c_vld = ($urandom_range(1) == 1);
            c_req = '{opcode: (($urandom_range(1) == 1) ? RD : WR),
                      address: {pick_tile(), 24'($urandom)}, data: $urandom};
            r_vld = ($urandom_range(1) == 1);
            r_req = '{opcode: RD_RSP, address: {pick_tile(), 24'($urandom)}, data: $urandom};
            fab_rdy = ($urandom_range(3) == 0) ? 5'($urandom) : 5'h1f;
            in_rsp = ($urandom_range(3) == 0);
            if ($urandom_range(49) == 0) loc = pick_tile();
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
